mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: ADDR  input  16  bus address from CPU.
REQ-004 SHALL have port: DATA_I  input  16  write data from CPU.
REQ-005 SHALL have port: DATA_O  output  16  read data to CPU.
REQ-006 SHALL have port: RD  input  1  read strobe.
REQ-007 SHALL have port: WR  input  1  write strobe.
REQ-008 SHALL have port: PORT_DATA  output  16  output stream data, FIFO head.
REQ-009 SHALL have port: PORT_VLD  output  1  output stream valid.
REQ-010 SHALL have port: PORT_RDY  input  1  output stream ready from sink.
REQ-011 SHALL have port: IRQ  output  1  timer interrupt request.

Function
REQ-012 SHALL decode the map as follows: 0x0000-0x00FF RAM; 0xFF00 TCNT; 0xFF01 TCTL; 0xFF02 STATUS; 0xFF03 TXDATA; all other addresses unmapped.
REQ-013 SHALL implement RAM as 256x16 with combinational read and a write on the rising edge when WR=1 and ADDR is in range; RAM contents are not reset.
REQ-014 SHALL drive DATA_O combinationally in the same cycle as RD=1 (zero wait states, because the CPU samples on the next edge), and SHALL drive 0x0000 when RD=0, when both RD=1 and WR=1, or when the address is unmapped or TXDATA.
REQ-015 SHALL, on simultaneous RD=1 and WR=1, perform the write and suppress all read side effects.
REQ-016 SHALL, on a TCNT write, load both the reload register and the counter with DATA_I; this takes priority over decrement in the same cycle.
REQ-017 SHALL define TCTL as: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable), bits 15:3 reading as 0; a TCTL read returns the control register.
REQ-018 SHALL, when EN=1 and count>1, decrement the count by 1 per cycle.
REQ-019 SHALL, when EN=1 and count==1, set EXP and load the count with AUTO ? reload : 0.
REQ-020 SHALL, when EN=1 and count==0, hold the count at 0 with no event; when EN=0, hold the count.
REQ-021 SHALL return the live count on a TCNT read.
REQ-022 SHALL define STATUS as: bit0 EXP, bit1 FULL, bit2 EMPTY, bit3 OVF, bits 15:4 = 0; the returned value is the pre-edge state.
REQ-023 SHALL clear EXP and OVF on the rising edge of a STATUS read (RD=1, WR=0); a set event in that same cycle wins, leaving the flag at 1.
REQ-024 SHALL drive IRQ = EXP & IE, combinationally from registers.
REQ-025 SHALL implement a 4-entry TX FIFO: a TXDATA write pushes DATA_I when not full; a write while full is dropped and sets OVF.
REQ-026 SHALL evaluate full and empty on pre-edge occupancy: a push when full is dropped even if a pop occurs in the same cycle; a push when empty is accepted, and no pop occurs in that cycle.
REQ-027 SHALL drive PORT_VLD = !EMPTY and PORT_DATA = FIFO head; 0x0000 when empty.
REQ-028 SHALL pop on a rising edge where PORT_VLD=1 and PORT_RDY=1, and SHALL hold PORT_DATA stable while PORT_VLD=1 and PORT_RDY=0.
REQ-029 SHALL use 2-bit read and write pointers that wrap 3->0, with a 3-bit occupancy count (0-4).
REQ-030 SHALL ignore writes to STATUS and unmapped addresses.

Reset
REQ-031 SHALL, while RST=1, immediately force the counter, reload register, TCTL, EXP, OVF, FIFO pointers and occupancy to 0, giving PORT_VLD=0, PORT_DATA=0, IRQ=0, and DATA_O=0x0000 unless RD=1.
REQ-032 SHALL discard FIFO contents and any in-progress countdown on reset mid-operation; RAM is retained.

Verification
REQ-033 Bench SHALL cover RAM: write 0x1234 @0x0010, then RD @0x0010 -> DATA_O=0x1234 in the same cycle; RD @0x0100 -> 0x0000.
REQ-034 Bench SHALL cover the timer: TCNT<-3, TCTL<-0x0007 -> EXP=1 and IRQ=1 three cycles after EN, then the count reloads to 3; a STATUS read returns bit0=1, then EXP=0 after the edge.
REQ-035 Bench SHALL cover FIFO overflow: PORT_RDY=0, write TXDATA 5 times (0xA0-0xA4) -> FULL=1, OVF=1, PORT_DATA=0xA0; PORT_RDY=1 -> 0xA0-0xA3 delivered in order, then PORT_VLD=0.
REQ-036 Bench SHALL cover boundary collisions: write to full FIFO with PORT_RDY=1 in the same cycle -> occupancy 3, OVF=1; push to empty FIFO with PORT_RDY=1 -> occupancy 1.
REQ-037 Bench SHALL cover the STATUS read/set race: STATUS read on the same cycle the count hits 1 -> EXP remains 1.
REQ-038 Bench SHALL cover reset mid-operation: assert RST with 2 FIFO entries and count=5 -> PORT_VLD=0, TCNT=0, IRQ=0 immediately; RAM data retained.

Source files
------------

// File: rtl/mem_responder_if.sv
// CPU bus and TX stream bundle for mem_responder.
// Stream rule: a word moves on a rising edge where PORT_VLD=1 and PORT_RDY=1; PORT_DATA holds while stalled.
interface mem_responder_if;
    logic [15:0] ADDR;
    logic [15:0] DATA_I;
    logic [15:0] DATA_O;
    logic        RD;
    logic        WR;
    logic [15:0] PORT_DATA;
    logic        PORT_VLD;
    logic        PORT_RDY;
    logic        IRQ;

    modport slave (
        input  ADDR, DATA_I, RD, WR, PORT_RDY,
        output DATA_O, PORT_DATA, PORT_VLD, IRQ
    );

    modport master (
        output ADDR, DATA_I, RD, WR, PORT_RDY,
        input  DATA_O, PORT_DATA, PORT_VLD, IRQ
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-mapped responder: 256x16 RAM, down-counting timer with IRQ, 4-entry TX FIFO.
// Reads are zero-wait-state combinational; all state updates on the rising edge.
module mem_responder (
    input logic            CLK,
    input logic            RST,
    mem_responder_if.slave bus
);
    localparam logic [15:0] A_TCNT   = 16'hFF00;
    localparam logic [15:0] A_TCTL   = 16'hFF01;
    localparam logic [15:0] A_STATUS = 16'hFF02;
    localparam logic [15:0] A_TXDATA = 16'hFF03;

    logic [15:0] ram_q  [256];
    logic [15:0] fifo_q [4];

    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] reload_q, reload_d;
    logic [2:0]  tctl_q, tctl_d;
    logic        exp_q, exp_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  wptr_q, wptr_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [2:0]  occ_q, occ_d;

    logic        sel_ram, sel_tcnt, sel_tctl, sel_status, sel_tx;
    logic        rd_only, fifo_full, fifo_empty;
    logic        push, drop, pop, exp_set, status_rd;
    logic [15:0] status_w, data_o;

    always_comb begin
        sel_ram    = (bus.ADDR[15:8] == 8'h00);
        sel_tcnt   = (bus.ADDR == A_TCNT);
        sel_tctl   = (bus.ADDR == A_TCTL);
        sel_status = (bus.ADDR == A_STATUS);
        sel_tx     = (bus.ADDR == A_TXDATA);
        rd_only    = bus.RD & ~bus.WR;
        status_rd  = rd_only & sel_status;
        fifo_full  = (occ_q == 3'd4);
        fifo_empty = (occ_q == 3'd0);
        // Full/empty are pre-edge: a push into a full FIFO is lost even if a pop frees a slot.
        push       = bus.WR & sel_tx & ~fifo_full;
        drop       = bus.WR & sel_tx & fifo_full;
        pop        = ~fifo_empty & bus.PORT_RDY;
        status_w   = {12'h000, ovf_q, fifo_empty, fifo_full, exp_q};
    end

    always_comb begin
        data_o = 16'h0000;
        if (rd_only) begin
            if (sel_ram)         data_o = ram_q[bus.ADDR[7:0]];
            else if (sel_tcnt)   data_o = tcnt_q;
            else if (sel_tctl)   data_o = {13'h0000, tctl_q};
            else if (sel_status) data_o = status_w;
        end
    end

    always_comb begin
        tcnt_d   = tcnt_q;
        reload_d = reload_q;
        tctl_d   = tctl_q;
        exp_set  = 1'b0;
        if (bus.WR && sel_tcnt) begin
            tcnt_d   = bus.DATA_I;
            reload_d = bus.DATA_I;
        end else if (tctl_q[0]) begin
            if (tcnt_q > 16'd1) begin
                tcnt_d = tcnt_q - 16'd1;
            end else if (tcnt_q == 16'd1) begin
                exp_set = 1'b1;
                tcnt_d  = tctl_q[1] ? reload_q : 16'h0000;
            end
        end
        if (bus.WR && sel_tctl) tctl_d = bus.DATA_I[2:0];
        // A set event in the same cycle as a STATUS read wins over the clear.
        exp_d  = exp_set | (exp_q & ~status_rd);
        ovf_d  = drop | (ovf_q & ~status_rd);
        wptr_d = push ? wptr_q + 2'd1 : wptr_q;
        rptr_d = pop ? rptr_q + 2'd1 : rptr_q;
        occ_d  = occ_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt_q   <= 16'h0000;
            reload_q <= 16'h0000;
            tctl_q   <= 3'b000;
            exp_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            occ_q    <= 3'd0;
        end else begin
            tcnt_q   <= tcnt_d;
            reload_q <= reload_d;
            tctl_q   <= tctl_d;
            exp_q    <= exp_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage arrays are not reset; RAM survives reset and FIFO slots are gated by occupancy.
    always_ff @(posedge CLK) begin
        if (bus.WR && sel_ram) ram_q[bus.ADDR[7:0]] <= bus.DATA_I;
        if (push)              fifo_q[wptr_q] <= bus.DATA_I;
    end

    assign bus.DATA_O    = data_o;
    assign bus.PORT_VLD  = ~fifo_empty;
    assign bus.PORT_DATA = fifo_empty ? 16'h0000 : fifo_q[rptr_q];
    assign bus.IRQ       = exp_q & tctl_q[2];
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic, all checked every cycle
// against a queue/array model of the register map, timer and TX FIFO.
module tb_mem_responder;
  logic clk;
  logic rst;
  mem_responder_if bus();

  mem_responder dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // model state
  logic [15:0] m_ram [256];
  logic [15:0] m_fifo [$];
  logic [15:0] m_cnt;
  logic [15:0] m_reload;
  logic [2:0]  m_ctl;
  logic        m_exp;
  logic        m_ovf;

  // values sampled by the last cycle
  logic [15:0] s_data_o;
  logic [15:0] s_pdata;
  logic        s_vld;
  logic        s_irq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] r;
    r = 16'h0000;
    r[0] = m_exp;
    r[1] = (m_fifo.size() == 4);
    r[2] = (m_fifo.size() == 0);
    r[3] = m_ovf;
    return r;
  endfunction

  function automatic logic [15:0] m_data_o(input logic [15:0] a, input logic rd, input logic wr);
    if (!rd || wr) return 16'h0000;
    if (a < 16'h0100) return m_ram[a[7:0]];
    case (a)
      16'hFF00: return m_cnt;
      16'hFF01: return {13'h0000, m_ctl};
      16'hFF02: return m_status();
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_cnt = 16'h0000;
    m_reload = 16'h0000;
    m_ctl = 3'b000;
    m_exp = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently on the bus.
  task automatic model_step();
    logic [15:0] a;
    logic [15:0] d;
    logic wr_e, rdo, full, empty, exp_set, ovf_set;
    a = bus.ADDR;
    d = bus.DATA_I;
    wr_e = bus.WR;
    rdo = bus.RD && !bus.WR;
    full = (m_fifo.size() == 4);
    empty = (m_fifo.size() == 0);
    exp_set = 1'b0;
    ovf_set = 1'b0;
    if (wr_e && a < 16'h0100) m_ram[a[7:0]] = d;
    if (wr_e && a == 16'hFF00) begin
      m_reload = d;
      m_cnt = d;
    end else if (m_ctl[0]) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else if (m_cnt == 1) begin
        exp_set = 1'b1;
        m_cnt = m_ctl[1] ? m_reload : 16'h0000;
      end
    end
    if (wr_e && a == 16'hFF01) m_ctl = d[2:0];
    if (!empty && bus.PORT_RDY) void'(m_fifo.pop_front());
    if (wr_e && a == 16'hFF03) begin
      if (full) ovf_set = 1'b1;
      else m_fifo.push_back(d);
    end
    if (exp_set) m_exp = 1'b1;
    else if (rdo && a == 16'hFF02) m_exp = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
    else if (rdo && a == 16'hFF02) m_ovf = 1'b0;
  endtask

  // Called at posedge+1 with inputs set: compare at negedge, then clock the model.
  task automatic cycle();
    @(negedge clk);
    s_data_o = bus.DATA_O;
    s_pdata  = bus.PORT_DATA;
    s_vld    = bus.PORT_VLD;
    s_irq    = bus.IRQ;
    chk("data_o", s_data_o, m_data_o(bus.ADDR, bus.RD, bus.WR));
    chk("port_vld", {15'h0, s_vld}, {15'h0, m_fifo.size() != 0});
    chk("port_data", s_pdata, (m_fifo.size() != 0) ? m_fifo[0] : 16'h0000);
    chk("irq", {15'h0, s_irq}, {15'h0, m_exp & m_ctl[2]});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic rd, input logic wr);
    bus.ADDR = a;
    bus.DATA_I = d;
    bus.RD = rd;
    bus.WR = wr;
    cycle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(a, d, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [15:0] a);
    drive(a, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    logic [15:0] a;
    logic [15:0] d;
    int sel;

    // reset
    rst = 1'b1;
    bus.ADDR = 16'h0000;
    bus.DATA_I = 16'h0000;
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    bus.PORT_RDY = 1'b0;
    model_reset();
    #3;
    chk("rst_vld", {15'h0, bus.PORT_VLD}, 16'h0000);
    chk("rst_pdata", bus.PORT_DATA, 16'h0000);
    chk("rst_irq", {15'h0, bus.IRQ}, 16'h0000);
    chk("rst_data_o", bus.DATA_O, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill RAM so every later read has a defined value
    for (int i = 0; i < 256; i++) wr(i[15:0], $urandom());

    // RAM
    wr(16'h0010, 16'h1234);
    rd(16'h0010);
    chk("ram_rd_0010", s_data_o, 16'h1234);
    rd(16'h0100);
    chk("unmapped_0100", s_data_o, 16'h0000);
    drive(16'h0010, 16'hBEEF, 1'b1, 1'b1);
    chk("rd_wr_both_zero", s_data_o, 16'h0000);
    rd(16'h0010);
    chk("rd_wr_both_wrote", s_data_o, 16'hBEEF);
    wr(16'h0010, 16'h1234);

    // timer: expires three edges after enable, reloads, and STATUS read/set race
    wr(16'hFF00, 16'd3);
    wr(16'hFF01, 16'h0007);
    idle();
    idle();
    idle();
    rd(16'hFF00);
    chk("tmr_reload", s_data_o, 16'd3);
    chk("tmr_irq", {15'h0, s_irq}, 16'h0001);
    rd(16'hFF02);
    chk("tmr_status_exp", s_data_o & 16'h0001, 16'h0001);
    rd(16'hFF02);
    chk("tmr_exp_cleared", s_data_o & 16'h0001, 16'h0000);
    chk("tmr_irq_cleared", {15'h0, s_irq}, 16'h0000);
    rd(16'hFF02);
    chk("tmr_race_set_wins", s_data_o & 16'h0001, 16'h0001);
    wr(16'hFF01, 16'h0000);
    rd(16'hFF01);
    chk("tctl_rd", s_data_o, 16'h0000);

    // FIFO overflow
    bus.PORT_RDY = 1'b0;
    for (int i = 0; i < 5; i++) wr(16'hFF03, 16'h00A0 + 16'(i));
    rd(16'hFF02);
    chk("ovf_full_ovf", s_data_o & 16'h000E, 16'h000A);
    chk("ovf_head", s_pdata, 16'h00A0);
    bus.PORT_RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("ovf_drain", s_pdata, 16'h00A0 + 16'(i));
    end
    idle();
    chk("ovf_drained_vld", {15'h0, s_vld}, 16'h0000);

    // push to a full FIFO while popping: dropped, occupancy 3
    bus.PORT_RDY = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'hFF03, 16'h00B0 + 16'(i));
    bus.PORT_RDY = 1'b1;
    wr(16'hFF03, 16'h00B4);
    bus.PORT_RDY = 1'b0;
    rd(16'hFF02);
    chk("coll_full_status", s_data_o & 16'h000E, 16'h0008);
    chk("coll_head", s_pdata, 16'h00B1);
    bus.PORT_RDY = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (!s_vld) break;
      n++;
    end
    chk("coll_occ3", 16'(n), 16'd3);

    // push to an empty FIFO while ready: accepted, occupancy 1
    wr(16'hFF03, 16'h00C0);
    bus.PORT_RDY = 1'b0;
    rd(16'hFF02);
    chk("empty_push_status", s_data_o & 16'h0006, 16'h0000);
    chk("empty_push_head", s_pdata, 16'h00C0);
    bus.PORT_RDY = 1'b1;
    idle();
    idle();
    chk("empty_push_occ1", {15'h0, s_vld}, 16'h0000);

    // reset mid-operation: 2 FIFO entries, count 5, IRQ pending
    bus.PORT_RDY = 1'b0;
    wr(16'hFF00, 16'd1);
    wr(16'hFF01, 16'h0007);
    idle();
    wr(16'hFF01, 16'h0000);
    wr(16'hFF03, 16'h00D0);
    wr(16'hFF03, 16'h00D1);
    wr(16'hFF00, 16'd5);
    wr(16'hFF01, 16'h0007);
    bus.ADDR = 16'hFF00;
    bus.RD = 1'b1;
    bus.WR = 1'b0;
    #1;
    chk("pre_rst_tcnt", bus.DATA_O, 16'd5);
    chk("pre_rst_irq", {15'h0, bus.IRQ}, 16'h0001);
    chk("pre_rst_vld", {15'h0, bus.PORT_VLD}, 16'h0001);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", {15'h0, bus.PORT_VLD}, 16'h0000);
    chk("mid_rst_pdata", bus.PORT_DATA, 16'h0000);
    chk("mid_rst_irq", {15'h0, bus.IRQ}, 16'h0000);
    chk("mid_rst_tcnt", bus.DATA_O, 16'h0000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    rd(16'h0010);
    chk("ram_retained", s_data_o, 16'h1234);
    rd(16'hFF02);
    chk("post_rst_status", s_data_o, 16'h0004);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 16'($urandom_range(0, 255));
        4:          a = 16'hFF00;
        5:          a = 16'hFF01;
        6:          a = 16'hFF02;
        7, 9:       a = 16'hFF03;
        default:    a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0100, 16'hFEFF))
                                                    : 16'($urandom_range(16'hFF04, 16'hFFFF));
      endcase
      d = 16'($urandom());
      if (a == 16'hFF00) d = 16'($urandom_range(0, 8));
      bus.PORT_RDY = ($urandom_range(0, 3) != 0);
      drive(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
